// File: rtl/rob_multi_commit.sv
// Reorder buffer: single-entry allocation, multi-port completion, in-order
// multi-wide commit and a full squash when a mispredicted branch retires.
module rob_multi_commit #(
  parameter int DEPTH      = 16,
  parameter int PREG_W     = 6,
  parameter int CMPL_PORTS = 2,
  parameter int COMMIT_W   = 2,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [4:0]                   alloc_rd_log,
  input  logic [PREG_W-1:0]            alloc_rd_phys,
  input  logic [PREG_W-1:0]            alloc_rd_old_phys,
  input  logic                         alloc_is_branch,
  input  logic [31:0]                  alloc_pc,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [CMPL_PORTS-1:0]        cmpl_valid,
  input  logic [CMPL_PORTS*TAG_W-1:0]  cmpl_tag,
  input  logic [CMPL_PORTS-1:0]        cmpl_mispred,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*5-1:0]        commit_rd_log,
  output logic [COMMIT_W*PREG_W-1:0]   commit_rd_phys,
  output logic [COMMIT_W*PREG_W-1:0]   commit_rd_old_phys,
  output logic                         flush_valid,
  output logic [31:0]                  flush_pc,
  output logic [TAG_W:0]               count
);

  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0]  mispred_q, mispred_d, is_branch_q, is_branch_d;
  logic [4:0]        rd_log_q [DEPTH];
  logic [4:0]        rd_log_d [DEPTH];
  logic [PREG_W-1:0] rd_phys_q [DEPTH];
  logic [PREG_W-1:0] rd_phys_d [DEPTH];
  logic [PREG_W-1:0] rd_old_phys_q [DEPTH];
  logic [PREG_W-1:0] rd_old_phys_d [DEPTH];
  logic [31:0]       pc_q [DEPTH];
  logic [31:0]       pc_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    cnt_q, cnt_d;
  logic [TAG_W:0]    n_ret;
  logic              alloc_fire;

  assign count       = cnt_q;
  assign alloc_tag   = tail_q;
  assign alloc_ready = (cnt_q != (TAG_W+1)'(DEPTH)) && !flush_valid;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // A lane retires only if every older lane retires and none of them is a
  // mispredicted branch, so the first blocked or mispredicted lane ends the scan.
  always_comb begin
    logic [TAG_W-1:0] idx;
    logic             blocked;
    commit_valid       = '0;
    commit_rd_log      = '0;
    commit_rd_phys     = '0;
    commit_rd_old_phys = '0;
    flush_valid        = 1'b0;
    flush_pc           = '0;
    n_ret              = '0;
    blocked            = 1'b0;
    idx                = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      idx = head_q + TAG_W'(i);
      if (!blocked && (cnt_q > (TAG_W+1)'(i)) && valid_q[idx] && done_q[idx]) begin
        commit_valid[i]                        = 1'b1;
        commit_rd_log[i*5 +: 5]                = rd_log_q[idx];
        commit_rd_phys[i*PREG_W +: PREG_W]     = rd_phys_q[idx];
        commit_rd_old_phys[i*PREG_W +: PREG_W] = rd_old_phys_q[idx];
        n_ret = n_ret + (TAG_W+1)'(1);
        if (mispred_q[idx]) begin
          flush_valid = 1'b1;
          flush_pc    = pc_q[idx];
          blocked     = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  // Completions are applied first, then retirement clears valid bits, then the
  // new allocation claims the tail slot; a flush overrides all of it.
  always_comb begin
    logic [TAG_W-1:0] tag;
    valid_d       = valid_q;
    done_d        = done_q;
    mispred_d     = mispred_q;
    is_branch_d   = is_branch_q;
    rd_log_d      = rd_log_q;
    rd_phys_d     = rd_phys_q;
    rd_old_phys_d = rd_old_phys_q;
    pc_d          = pc_q;
    head_d        = head_q + n_ret[TAG_W-1:0];
    tail_d        = tail_q;
    cnt_d         = cnt_q - n_ret;
    tag           = '0;
    if (!flush_valid) begin
      for (int p = 0; p < CMPL_PORTS; p++) begin
        tag = cmpl_tag[p*TAG_W +: TAG_W];
        if (cmpl_valid[p] && valid_q[tag]) begin
          done_d[tag] = 1'b1;
          if (is_branch_q[tag] && cmpl_mispred[p]) mispred_d[tag] = 1'b1;
        end
      end
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid[i]) valid_d[head_q + TAG_W'(i)] = 1'b0;
    end
    if (flush_valid) begin
      valid_d = '0;
      tail_d  = head_d;
      cnt_d   = '0;
    end else if (alloc_fire) begin
      valid_d[tail_q]       = 1'b1;
      done_d[tail_q]        = 1'b0;
      mispred_d[tail_q]     = 1'b0;
      is_branch_d[tail_q]   = alloc_is_branch;
      rd_log_d[tail_q]      = alloc_rd_log;
      rd_phys_d[tail_q]     = alloc_rd_phys;
      rd_old_phys_d[tail_q] = alloc_rd_old_phys;
      pc_d[tail_q]          = alloc_pc;
      tail_d                = tail_q + TAG_W'(1);
      cnt_d                 = cnt_d + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      done_q      <= '0;
      mispred_q   <= '0;
      is_branch_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      mispred_q   <= mispred_d;
      is_branch_q <= is_branch_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_log_q      <= rd_log_d;
    rd_phys_q     <= rd_phys_d;
    rd_old_phys_q <= rd_old_phys_d;
    pc_q          <= pc_d;
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: per-cycle vector table plus hand-written
// sequences, with a queue scoreboard tracking retirement order and payload.
module tb_rob_multi_commit;

  localparam int DEPTH = 16;
  localparam int PREG_W = 6;
  localparam int CMPL_PORTS = 2;
  localparam int COMMIT_W = 2;
  localparam int TAG_W = 4;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        alloc_valid = 1'b0;
  logic                        alloc_ready;
  logic [4:0]                  alloc_rd_log = '0;
  logic [PREG_W-1:0]           alloc_rd_phys = '0;
  logic [PREG_W-1:0]           alloc_rd_old_phys = '0;
  logic                        alloc_is_branch = 1'b0;
  logic [31:0]                 alloc_pc = '0;
  logic [TAG_W-1:0]            alloc_tag;
  logic [CMPL_PORTS-1:0]       cmpl_valid = '0;
  logic [CMPL_PORTS*TAG_W-1:0] cmpl_tag = '0;
  logic [CMPL_PORTS-1:0]       cmpl_mispred = '0;
  logic [COMMIT_W-1:0]         commit_valid;
  logic [COMMIT_W*5-1:0]       commit_rd_log;
  logic [COMMIT_W*PREG_W-1:0]  commit_rd_phys;
  logic [COMMIT_W*PREG_W-1:0]  commit_rd_old_phys;
  logic                        flush_valid;
  logic [31:0]                 flush_pc;
  logic [TAG_W:0]              count;

  int checks = 0;
  int errors = 0;
  int n_committed = 0;

  rob_multi_commit #(.DEPTH(DEPTH), .PREG_W(PREG_W), .CMPL_PORTS(CMPL_PORTS),
                     .COMMIT_W(COMMIT_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rd_log(alloc_rd_log), .alloc_rd_phys(alloc_rd_phys),
    .alloc_rd_old_phys(alloc_rd_old_phys), .alloc_is_branch(alloc_is_branch),
    .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_mispred(cmpl_mispred),
    .commit_valid(commit_valid), .commit_rd_log(commit_rd_log),
    .commit_rd_phys(commit_rd_phys), .commit_rd_old_phys(commit_rd_old_phys),
    .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        rd_log;
    logic [PREG_W-1:0] rd_phys;
    logic [PREG_W-1:0] rd_old;
    logic [31:0]       pc;
  } sb_t;

  typedef struct {
    bit         do_reset;
    bit         alloc;
    bit         is_br;
    int         seq;
    logic [1:0] cv;
    logic [3:0] t0;
    logic [3:0] t1;
    logic [1:0] mp;
    logic [1:0] exp_cv;
    logic [4:0] exp_cnt;
    bit         exp_flush;
    bit         exp_ready;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid     = 1'b0;
    alloc_is_branch = 1'b0;
    cmpl_valid      = '0;
    cmpl_tag        = '0;
    cmpl_mispred    = '0;
  endtask

  task automatic set_alloc(input int seq, input bit br);
    alloc_valid       = 1'b1;
    alloc_is_branch   = br;
    alloc_rd_log      = 5'(seq % 32);
    alloc_rd_phys     = 6'((seq * 7 + 3) % 64);
    alloc_rd_old_phys = 6'(seq % 64);
    alloc_pc          = 32'h1000 + 32'(seq * 4);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic add_vec(input bit rst_b, input bit al, input bit br, input int seq,
                         input logic [1:0] cv, input logic [3:0] t0, input logic [3:0] t1,
                         input logic [1:0] mp, input logic [1:0] ecv, input logic [4:0] ecnt,
                         input bit efl, input bit erdy);
    vec_t v;
    v.do_reset = rst_b; v.alloc = al; v.is_br = br; v.seq = seq;
    v.cv = cv; v.t0 = t0; v.t1 = t1; v.mp = mp;
    v.exp_cv = ecv; v.exp_cnt = ecnt; v.exp_flush = efl; v.exp_ready = erdy;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    idle();
    if (v.alloc) set_alloc(v.seq, v.is_br);
    cmpl_valid   = v.cv;
    cmpl_tag     = {v.t1, v.t0};
    cmpl_mispred = v.mp;
  endtask

  task automatic check_output(input vec_t v, input int k);
    check($sformatf("vec%0d commit_valid", k), 64'(commit_valid), 64'(v.exp_cv));
    check($sformatf("vec%0d count", k), 64'(count), 64'(v.exp_cnt));
    check($sformatf("vec%0d flush_valid", k), 64'(flush_valid), 64'(v.exp_flush));
    check($sformatf("vec%0d alloc_ready", k), 64'(alloc_ready), 64'(v.exp_ready));
  endtask

  // Retirement monitor: pops one expected entry per valid lane, checks the
  // flush PC against the last retired entry and drops squashed entries.
  always @(negedge clk) begin
    sb_t         e;
    bit          have_pc;
    logic [31:0] last_pc;
    have_pc = 1'b0;
    last_pc = '0;
    if (reset) begin
      sb.delete();
    end else begin
      for (int i = 0; i < COMMIT_W; i++) begin
        if (commit_valid[i]) begin
          if (i > 0) check("lane_contiguous", 64'(commit_valid[i-1]), 64'd1);
          if (sb.size() == 0) begin
            check("unexpected_commit", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            check("commit_rd_old_phys", 64'(commit_rd_old_phys[i*PREG_W +: PREG_W]), 64'(e.rd_old));
            check("commit_rd_phys", 64'(commit_rd_phys[i*PREG_W +: PREG_W]), 64'(e.rd_phys));
            check("commit_rd_log", 64'(commit_rd_log[i*5 +: 5]), 64'(e.rd_log));
            last_pc = e.pc;
            have_pc = 1'b1;
            n_committed++;
          end
        end
      end
      if (flush_valid) begin
        check("flush_has_commit", 64'(have_pc), 64'd1);
        check("flush_pc", 64'(flush_pc), 64'(last_pc));
        sb.delete();
      end
      if (alloc_valid && alloc_ready) begin
        e.rd_log  = alloc_rd_log;
        e.rd_phys = alloc_rd_phys;
        e.rd_old  = alloc_rd_old_phys;
        e.pc      = alloc_pc;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int d;

    // In-order pair commit; a non-branch reporting mispredict must not flush.
    add_vec(1, 1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    add_vec(0, 1, 0, 1, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 1);
    add_vec(0, 1, 0, 2, 2'b00, 0, 0, 2'b00, 2'b00, 2, 0, 1);
    add_vec(0, 1, 0, 3, 2'b00, 0, 0, 2'b00, 2'b00, 3, 0, 1);
    add_vec(0, 0, 0, 0, 2'b01, 3, 0, 2'b01, 2'b00, 4, 0, 1);
    add_vec(0, 0, 0, 0, 2'b01, 2, 0, 2'b00, 2'b00, 4, 0, 1);
    add_vec(0, 0, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00, 4, 0, 1);
    add_vec(0, 0, 0, 0, 2'b01, 0, 0, 2'b01, 2'b00, 4, 0, 1);
    add_vec(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11, 4, 0, 1);
    add_vec(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b11, 2, 0, 1);
    add_vec(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    // Mispredicted branch in lane 1 flushes younger entries and blocks alloc.
    add_vec(1, 1, 0, 10, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    add_vec(0, 1, 1, 11, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 1);
    add_vec(0, 1, 0, 12, 2'b00, 0, 0, 2'b00, 2'b00, 2, 0, 1);
    add_vec(0, 1, 0, 13, 2'b00, 0, 0, 2'b00, 2'b00, 3, 0, 1);
    add_vec(0, 0, 0, 0, 2'b11, 2, 3, 2'b00, 2'b00, 4, 0, 1);
    add_vec(0, 0, 0, 0, 2'b11, 0, 1, 2'b10, 2'b00, 4, 0, 1);
    add_vec(0, 1, 0, 14, 2'b00, 0, 0, 2'b00, 2'b11, 4, 1, 0);
    add_vec(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    add_vec(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    // Both ports hit the same branch tag, one mispredicted.
    add_vec(1, 1, 1, 20, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    add_vec(0, 1, 0, 21, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 1);
    add_vec(0, 0, 0, 0, 2'b11, 0, 0, 2'b10, 2'b00, 2, 0, 1);
    add_vec(0, 0, 0, 0, 2'b01, 1, 0, 2'b00, 2'b01, 2, 1, 0);
    add_vec(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    add_vec(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);

    $display("[TB] reset state");
    idle();
    reset = 1'b1;
    #2;
    check("reset alloc_ready", 64'(alloc_ready), 64'd1);
    check("reset commit_valid", 64'(commit_valid), 64'd0);
    check("reset flush_valid", 64'(flush_valid), 64'd0);
    check("reset count", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] fill to full, then retire one");
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      idle();
      set_alloc(i, 0);
      #1;
      check($sformatf("fill%0d alloc_ready", i), 64'(alloc_ready), 64'd1);
      check($sformatf("fill%0d alloc_tag", i), 64'(alloc_tag), 64'(i));
    end
    cycle();
    idle();
    cmpl_valid = 2'b01;
    cmpl_tag   = '0;
    #1;
    check("full count", 64'(count), 64'd16);
    check("full alloc_ready", 64'(alloc_ready), 64'd0);
    check("full commit_valid", 64'(commit_valid), 64'd0);
    cycle();
    idle();
    set_alloc(16, 0);
    #1;
    check("full retire commit_valid", 64'(commit_valid), 64'b01);
    check("full retire alloc_ready", 64'(alloc_ready), 64'd0);
    check("full retire count", 64'(count), 64'd16);
    cycle();
    idle();
    #1;
    check("after retire count", 64'(count), 64'd15);
    check("after retire alloc_ready", 64'(alloc_ready), 64'd1);
    check("after retire commit_valid", 64'(commit_valid), 64'd0);

    $display("[TB] vector table");
    foreach (vecs[k]) begin
      if (vecs[k].do_reset) do_reset();
      cycle();
      apply_stimulus(vecs[k]);
      #1;
      check_output(vecs[k], k);
    end

    $display("[TB] wraparound stream");
    do_reset();
    base = n_committed;
    for (int n = 0; n < 40; n++) begin
      cycle();
      idle();
      set_alloc(100 + n, 0);
      #1;
      check($sformatf("wrap%0d alloc_tag", n), 64'(alloc_tag), 64'(n % DEPTH));
      d = int'($urandom_range(0, 3));
      for (int j = 0; j < d; j++) begin
        cycle();
        idle();
      end
      cycle();
      idle();
      cmpl_valid = 2'b01;
      cmpl_tag   = {4'd0, 4'(n % DEPTH)};
    end
    cycle();
    idle();
    repeat (3) cycle();
    check("wrap committed", 64'(n_committed - base), 64'd40);
    check("wrap count", 64'(count), 64'd0);
    check("wrap scoreboard empty", 64'(sb.size()), 64'd0);

    $display("[TB] reset with done entries");
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle();
      idle();
      set_alloc(30 + i, 0);
    end
    cycle();
    idle();
    cmpl_valid = 2'b11;
    cmpl_tag   = {4'd3, 4'd4};
    cycle();
    idle();
    cmpl_valid = 2'b11;
    cmpl_tag   = {4'd1, 4'd2};
    cycle();
    idle();
    cmpl_valid = 2'b01;
    cmpl_tag   = {4'd0, 4'd0};
    #1;
    check("pre-reset commit_valid idle", 64'(commit_valid), 64'd0);
    cycle();
    idle();
    #1;
    check("pre-reset commit_valid", 64'(commit_valid), 64'b11);
    check("pre-reset count", 64'(count), 64'd5);
    reset = 1'b1;
    #1;
    check("mid reset commit_valid", 64'(commit_valid), 64'd0);
    check("mid reset count", 64'(count), 64'd0);
    check("mid reset alloc_ready", 64'(alloc_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
    set_alloc(40, 0);
    #1;
    check("post reset alloc_tag", 64'(alloc_tag), 64'd0);
    cycle();
    idle();
    #1;
    check("post reset count", 64'(count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
